// File: rtl/axi_lite_width_downsizer.sv
// AXI4-Lite width adapter: splits one wide upstream transaction into a
// sequence of narrow downstream beats, one transaction in flight at a time.
module axi_lite_width_downsizer #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned MST_DW     = 64,
  parameter int unsigned SLV_DW     = 32,
  parameter bit          SKIP_EMPTY = 1'b1
) (
  input  logic                  chipset_clk,
  input  logic                  chipset_rst_n,
  input  logic [ADDR_W-1:0]     up_awaddr,
  input  logic                  up_awvalid,
  output logic                  up_awready,
  input  logic [MST_DW-1:0]     up_wdata,
  input  logic [MST_DW/8-1:0]   up_wstrb,
  input  logic                  up_wvalid,
  output logic                  up_wready,
  output logic [1:0]            up_bresp,
  output logic                  up_bvalid,
  input  logic                  up_bready,
  input  logic [ADDR_W-1:0]     up_araddr,
  input  logic                  up_arvalid,
  output logic                  up_arready,
  output logic [MST_DW-1:0]     up_rdata,
  output logic [1:0]            up_rresp,
  output logic                  up_rvalid,
  input  logic                  up_rready,
  output logic [ADDR_W-1:0]     dn_awaddr,
  output logic                  dn_awvalid,
  input  logic                  dn_awready,
  output logic [SLV_DW-1:0]     dn_wdata,
  output logic [SLV_DW/8-1:0]   dn_wstrb,
  output logic                  dn_wvalid,
  input  logic                  dn_wready,
  input  logic [1:0]            dn_bresp,
  input  logic                  dn_bvalid,
  output logic                  dn_bready,
  output logic [ADDR_W-1:0]     dn_araddr,
  output logic                  dn_arvalid,
  input  logic                  dn_arready,
  input  logic [SLV_DW-1:0]     dn_rdata,
  input  logic [1:0]            dn_rresp,
  input  logic                  dn_rvalid,
  output logic                  dn_rready
);

  localparam int unsigned RATIO     = MST_DW / SLV_DW;
  localparam int unsigned IDX_W     = $clog2(RATIO);
  localparam int unsigned CNT_W     = IDX_W + 1;
  localparam int unsigned SLV_SB    = SLV_DW / 8;
  localparam int unsigned MST_OFF_W = $clog2(MST_DW / 8);
  localparam int unsigned SLV_OFF_W = $clog2(SLV_SB);

  typedef logic [RATIO-1:0][SLV_DW-1:0] data_arr_t;
  typedef logic [RATIO-1:0][SLV_SB-1:0] strb_arr_t;

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_RSP, W_DONE, R_REQ, R_RSP, R_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  data_arr_t         wdata_q, wdata_d;
  strb_arr_t         wstrb_q, wstrb_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [1:0]        resp_q, resp_d;

  logic              up_awready_q, up_awready_d;
  logic              up_arready_q, up_arready_d;
  logic              up_bvalid_q, up_bvalid_d;
  logic [1:0]        up_bresp_q, up_bresp_d;
  logic              up_rvalid_q, up_rvalid_d;
  data_arr_t         rdata_q, rdata_d;
  logic [1:0]        up_rresp_q, up_rresp_d;
  logic [ADDR_W-1:0] dn_awaddr_q, dn_awaddr_d;
  logic              dn_awvalid_q, dn_awvalid_d;
  logic [SLV_DW-1:0] dn_wdata_q, dn_wdata_d;
  logic [SLV_SB-1:0] dn_wstrb_q, dn_wstrb_d;
  logic              dn_wvalid_q, dn_wvalid_d;
  logic              dn_bready_q, dn_bready_d;
  logic [ADDR_W-1:0] dn_araddr_q, dn_araddr_d;
  logic              dn_arvalid_q, dn_arvalid_d;
  logic              dn_rready_q, dn_rready_d;

  logic              load_w;
  logic [CNT_W-1:0]  load_idx;
  logic [ADDR_W-1:0] src_base;
  data_arr_t         src_data;
  strb_arr_t         src_strb;
  logic              wr_pend, rd_pend;

  // Lowest beat index >= from that must be issued; RATIO when none remain.
  function automatic logic [CNT_W-1:0] find_beat(input strb_arr_t s, input logic [CNT_W-1:0] from);
    logic [CNT_W-1:0] idx;
    idx = CNT_W'(RATIO);
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (CNT_W'(k) >= from && (!SKIP_EMPTY || s[k] != '0)) idx = CNT_W'(k);
    end
    return idx;
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign wr_pend = up_awvalid && up_wvalid;
  assign rd_pend = up_arvalid;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_wr_d    = last_wr_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    beat_d       = beat_q;
    resp_d       = resp_q;
    up_awready_d = up_awready_q;
    up_arready_d = up_arready_q;
    up_bvalid_d  = up_bvalid_q;
    up_bresp_d   = up_bresp_q;
    up_rvalid_d  = up_rvalid_q;
    rdata_d      = rdata_q;
    up_rresp_d   = up_rresp_q;
    dn_awaddr_d  = dn_awaddr_q;
    dn_awvalid_d = dn_awvalid_q;
    dn_wdata_d   = dn_wdata_q;
    dn_wstrb_d   = dn_wstrb_q;
    dn_wvalid_d  = dn_wvalid_q;
    dn_bready_d  = dn_bready_q;
    dn_araddr_d  = dn_araddr_q;
    dn_arvalid_d = dn_arvalid_q;
    dn_rready_d  = dn_rready_q;
    load_w       = 1'b0;
    load_idx     = beat_q;
    src_base     = base_q;
    src_data     = wdata_q;
    src_strb     = wstrb_q;

    unique case (state_q)
      IDLE: begin
        // Ready is raised one cycle after the grant so it never depends on inputs.
        if (up_awready_q) begin
          up_awready_d = 1'b0;
          if (wr_pend) begin
            last_wr_d = 1'b1;
            base_d    = {up_awaddr[ADDR_W-1:MST_OFF_W], MST_OFF_W'(0)};
            wdata_d   = up_wdata;
            wstrb_d   = up_wstrb;
            resp_d    = 2'b00;
            src_base  = base_d;
            src_data  = wdata_d;
            src_strb  = wstrb_d;
            load_idx  = find_beat(wstrb_d, '0);
            if (load_idx == CNT_W'(RATIO)) begin
              state_d     = W_DONE;
              up_bvalid_d = 1'b1;
              up_bresp_d  = 2'b00;
            end else begin
              load_w  = 1'b1;
              state_d = W_REQ;
            end
          end
        end else if (up_arready_q) begin
          up_arready_d = 1'b0;
          if (rd_pend) begin
            last_wr_d    = 1'b0;
            base_d       = {up_araddr[ADDR_W-1:MST_OFF_W], MST_OFF_W'(0)};
            resp_d       = 2'b00;
            beat_d       = '0;
            dn_araddr_d  = base_d;
            dn_arvalid_d = 1'b1;
            state_d      = R_REQ;
          end
        end else if (wr_pend && (!rd_pend || !last_wr_q)) begin
          up_awready_d = 1'b1;
        end else if (rd_pend) begin
          up_arready_d = 1'b1;
        end
      end
      W_REQ: begin
        dn_awvalid_d = dn_awvalid_q && !dn_awready;
        dn_wvalid_d  = dn_wvalid_q && !dn_wready;
        if (!dn_awvalid_d && !dn_wvalid_d) begin
          state_d     = W_RSP;
          dn_bready_d = 1'b1;
        end
      end
      W_RSP: begin
        if (dn_bvalid) begin
          dn_bready_d = 1'b0;
          resp_d      = resp_max(resp_q, dn_bresp);
          load_idx    = find_beat(wstrb_q, beat_q + CNT_W'(1));
          if (load_idx == CNT_W'(RATIO)) begin
            state_d     = W_DONE;
            up_bvalid_d = 1'b1;
            up_bresp_d  = resp_d;
          end else begin
            load_w  = 1'b1;
            state_d = W_REQ;
          end
        end
      end
      W_DONE: begin
        if (up_bready) begin
          up_bvalid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      R_REQ: begin
        if (dn_arready) begin
          dn_arvalid_d = 1'b0;
          dn_rready_d  = 1'b1;
          state_d      = R_RSP;
        end
      end
      R_RSP: begin
        if (dn_rvalid) begin
          dn_rready_d                = 1'b0;
          rdata_d[beat_q[IDX_W-1:0]] = dn_rdata;
          resp_d                     = resp_max(resp_q, dn_rresp);
          if (beat_q == CNT_W'(RATIO - 1)) begin
            state_d     = R_DONE;
            up_rvalid_d = 1'b1;
            up_rresp_d  = resp_d;
          end else begin
            beat_d       = beat_q + CNT_W'(1);
            dn_araddr_d  = base_q + (ADDR_W'(beat_d) << SLV_OFF_W);
            dn_arvalid_d = 1'b1;
            state_d      = R_REQ;
          end
        end
      end
      R_DONE: begin
        if (up_rready) begin
          up_rvalid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_w) begin
      beat_d       = load_idx;
      dn_awaddr_d  = src_base + (ADDR_W'(load_idx) << SLV_OFF_W);
      dn_wdata_d   = src_data[load_idx[IDX_W-1:0]];
      dn_wstrb_d   = src_strb[load_idx[IDX_W-1:0]];
      dn_awvalid_d = 1'b1;
      dn_wvalid_d  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) begin
      state_q      <= IDLE;
      last_wr_q    <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      beat_q       <= '0;
      resp_q       <= '0;
      up_awready_q <= 1'b0;
      up_arready_q <= 1'b0;
      up_bvalid_q  <= 1'b0;
      up_bresp_q   <= '0;
      up_rvalid_q  <= 1'b0;
      rdata_q      <= '0;
      up_rresp_q   <= '0;
      dn_awaddr_q  <= '0;
      dn_awvalid_q <= 1'b0;
      dn_wdata_q   <= '0;
      dn_wstrb_q   <= '0;
      dn_wvalid_q  <= 1'b0;
      dn_bready_q  <= 1'b0;
      dn_araddr_q  <= '0;
      dn_arvalid_q <= 1'b0;
      dn_rready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_wr_q    <= last_wr_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      beat_q       <= beat_d;
      resp_q       <= resp_d;
      up_awready_q <= up_awready_d;
      up_arready_q <= up_arready_d;
      up_bvalid_q  <= up_bvalid_d;
      up_bresp_q   <= up_bresp_d;
      up_rvalid_q  <= up_rvalid_d;
      rdata_q      <= rdata_d;
      up_rresp_q   <= up_rresp_d;
      dn_awaddr_q  <= dn_awaddr_d;
      dn_awvalid_q <= dn_awvalid_d;
      dn_wdata_q   <= dn_wdata_d;
      dn_wstrb_q   <= dn_wstrb_d;
      dn_wvalid_q  <= dn_wvalid_d;
      dn_bready_q  <= dn_bready_d;
      dn_araddr_q  <= dn_araddr_d;
      dn_arvalid_q <= dn_arvalid_d;
      dn_rready_q  <= dn_rready_d;
    end
  end

  assign up_awready = up_awready_q;
  assign up_wready  = up_awready_q;
  assign up_arready = up_arready_q;
  assign up_bvalid  = up_bvalid_q;
  assign up_bresp   = up_bresp_q;
  assign up_rvalid  = up_rvalid_q;
  assign up_rdata   = rdata_q;
  assign up_rresp   = up_rresp_q;
  assign dn_awaddr  = dn_awaddr_q;
  assign dn_awvalid = dn_awvalid_q;
  assign dn_wdata   = dn_wdata_q;
  assign dn_wstrb   = dn_wstrb_q;
  assign dn_wvalid  = dn_wvalid_q;
  assign dn_bready  = dn_bready_q;
  assign dn_araddr  = dn_araddr_q;
  assign dn_arvalid = dn_arvalid_q;
  assign dn_rready  = dn_rready_q;

endmodule

// File: tb/tb_axi_lite_width_downsizer.sv
// Directed bench for axi_lite_width_downsizer (64 -> 32 bit, empty beats skipped)
// with a behavioural downstream slave and hand-computed expectations.
module tb_axi_lite_width_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] up_awaddr, up_araddr, up_wdata, up_rdata;
  logic [7:0]  up_wstrb;
  logic        up_awvalid, up_awready, up_wvalid, up_wready;
  logic [1:0]  up_bresp, up_rresp;
  logic        up_bvalid, up_bready, up_arvalid, up_arready, up_rvalid, up_rready;
  logic [63:0] dn_awaddr, dn_araddr;
  logic        dn_awvalid, dn_awready, dn_wvalid, dn_wready;
  logic [31:0] dn_wdata, dn_rdata;
  logic [3:0]  dn_wstrb;
  logic [1:0]  dn_bresp, dn_rresp;
  logic        dn_bvalid, dn_bready, dn_arvalid, dn_arready, dn_rvalid, dn_rready;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int t0 = 0;

  // Downstream slave model state and logs.
  logic        aw_got, w_got, ar_got;
  bit          rd_beat;
  int          aw_stall = 0;
  int          awv_cnt, wv_cnt, bready_cyc;
  logic [31:0] rd_data [2];
  logic [1:0]  rd_resp [2];
  logic [63:0] aw_log [$];
  int          aw_cyc [$];
  logic [35:0] w_log [$];
  logic [63:0] ar_log [$];

  axi_lite_width_downsizer #(
    .ADDR_W(64), .MST_DW(64), .SLV_DW(32), .SKIP_EMPTY(1'b1)
  ) dut (
    .chipset_clk(clk), .chipset_rst_n(rst_n),
    .up_awaddr(up_awaddr), .up_awvalid(up_awvalid), .up_awready(up_awready),
    .up_wdata(up_wdata), .up_wstrb(up_wstrb), .up_wvalid(up_wvalid), .up_wready(up_wready),
    .up_bresp(up_bresp), .up_bvalid(up_bvalid), .up_bready(up_bready),
    .up_araddr(up_araddr), .up_arvalid(up_arvalid), .up_arready(up_arready),
    .up_rdata(up_rdata), .up_rresp(up_rresp), .up_rvalid(up_rvalid), .up_rready(up_rready),
    .dn_awaddr(dn_awaddr), .dn_awvalid(dn_awvalid), .dn_awready(dn_awready),
    .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb), .dn_wvalid(dn_wvalid), .dn_wready(dn_wready),
    .dn_bresp(dn_bresp), .dn_bvalid(dn_bvalid), .dn_bready(dn_bready),
    .dn_araddr(dn_araddr), .dn_arvalid(dn_arvalid), .dn_arready(dn_arready),
    .dn_rdata(dn_rdata), .dn_rresp(dn_rresp), .dn_rvalid(dn_rvalid), .dn_rready(dn_rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: ready per config, response the cycle after the request handshake.
  initial begin
    aw_got = 0; w_got = 0; ar_got = 0; rd_beat = 0;
    dn_awready = 1; dn_wready = 1; dn_arready = 1;
    dn_bvalid = 0; dn_bresp = 0; dn_rvalid = 0; dn_rdata = 0; dn_rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_got = 0; w_got = 0; ar_got = 0; rd_beat = 0;
        dn_bvalid = 0; dn_rvalid = 0; dn_awready = 1;
      end else begin
        dn_awready = (aw_stall == 0);
        dn_bvalid  = aw_got && w_got;
        dn_bresp   = 2'b00;
        if (dn_bvalid && dn_bready) begin aw_got = 0; w_got = 0; end
        if (dn_awvalid && dn_awready) begin
          aw_got = 1; aw_log.push_back(dn_awaddr); aw_cyc.push_back(cyc);
        end
        if (dn_awvalid && !dn_awready) aw_stall--;
        if (dn_wvalid && dn_wready) begin w_got = 1; w_log.push_back({dn_wstrb, dn_wdata}); end
        if (dn_awvalid) awv_cnt++;
        if (dn_wvalid) wv_cnt++;
        if (dn_bready && bready_cyc < 0) bready_cyc = cyc;
        dn_rvalid = ar_got;
        dn_rdata  = rd_data[rd_beat];
        dn_rresp  = rd_resp[rd_beat];
        if (dn_rvalid && dn_rready) begin ar_got = 0; rd_beat = ~rd_beat; end
        if (dn_arvalid && dn_arready) begin ar_got = 1; ar_log.push_back(dn_araddr); end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic clear_logs();
    aw_log.delete(); aw_cyc.delete(); w_log.delete(); ar_log.delete();
    awv_cnt = 0; wv_cnt = 0; bready_cyc = -1;
  endtask

  task automatic wait_accept(input string tag, output logic [1:0] who);
    who = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (up_awready || up_arready) begin
        who = {up_awready, up_arready};
        t0  = cyc;
        return;
      end
    end
    check({tag, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  // Returns at the negedge of the first cycle after the B handshake.
  task automatic wait_b(input string tag, input int lat, input logic [1:0] resp, input int stall);
    logic ok;
    for (int i = 0; i < 60 && !up_bvalid; i++) @(negedge clk);
    if (!up_bvalid) begin
      check({tag, "_b_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_b_lat"}, 64'(cyc - t0), 64'(lat));
    check({tag, "_bresp"}, 64'(up_bresp), 64'(resp));
    if (stall > 0) begin
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!up_bvalid || up_bresp !== resp || up_awready || up_arready) ok = 1'b0;
      end
      check({tag, "_b_hold"}, 64'(ok), 64'd1);
    end
    up_bready = 1;
    @(negedge clk);
    up_bready = 0;
  endtask

  task automatic wait_r(input string tag, input int lat, input logic [63:0] data, input logic [1:0] resp);
    for (int i = 0; i < 60 && !up_rvalid; i++) @(negedge clk);
    if (!up_rvalid) begin
      check({tag, "_r_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_r_lat"}, 64'(cyc - t0), 64'(lat));
    check({tag, "_rdata"}, up_rdata, data);
    check({tag, "_rresp"}, 64'(up_rresp), 64'(resp));
    up_rready = 1;
    @(negedge clk);
    up_rready = 0;
  endtask

  task automatic start_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    up_awaddr = a; up_wdata = d; up_wstrb = s;
    up_awvalid = 1; up_wvalid = 1;
  endtask

  task automatic write_txn(input string tag, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s, input int lat, input int stall);
    logic [1:0] who;
    start_write(a, d, s);
    wait_accept(tag, who);
    check({tag, "_grant"}, 64'(who), 64'(2'b10));
    @(negedge clk);
    up_awvalid = 0; up_wvalid = 0;
    wait_b(tag, lat, 2'b00, stall);
  endtask

  initial begin
    logic [1:0] who;
    up_awaddr = 0; up_wdata = 0; up_wstrb = 0; up_awvalid = 0; up_wvalid = 0;
    up_bready = 0; up_araddr = 0; up_arvalid = 0; up_rready = 0;
    rd_data[0] = 0; rd_data[1] = 0; rd_resp[0] = 0; rd_resp[1] = 0;
    clear_logs();
    apply_reset();

    check("reset_ctrl", 64'({up_awready, up_wready, up_arready, up_bvalid, up_rvalid,
                             dn_awvalid, dn_wvalid, dn_bready, dn_arvalid, dn_rready}), 64'd0);
    check("reset_data", up_rdata | dn_awaddr | dn_araddr | 64'(dn_wdata) |
                        64'({up_bresp, up_rresp, dn_wstrb}), 64'd0);

    // Full-strobe write split into two beats.
    clear_logs();
    write_txn("wr_full", 64'h1008, 64'h1111_2222_3333_4444, 8'hFF, 5, 0);
    check("wr_full_nbeats", 64'(aw_log.size()), 64'd2);
    if (aw_log.size() == 2 && w_log.size() == 2) begin
      check("wr_full_a0", aw_log[0], 64'h1008);
      check("wr_full_w0", 64'(w_log[0]), {28'd0, 4'hF, 32'h3333_4444});
      check("wr_full_t0", 64'(aw_cyc[0] - t0), 64'd1);
      check("wr_full_a1", aw_log[1], 64'h100C);
      check("wr_full_w1", 64'(w_log[1]), {28'd0, 4'hF, 32'h1111_2222});
      check("wr_full_t1", 64'(aw_cyc[1] - t0), 64'd3);
    end

    // Upper half only: one beat.
    clear_logs();
    write_txn("wr_hi", 64'h1008, 64'h1111_2222_3333_4444, 8'hF0, 3, 0);
    check("wr_hi_nbeats", 64'(aw_log.size()), 64'd1);
    if (aw_log.size() == 1 && w_log.size() == 1) begin
      check("wr_hi_a", aw_log[0], 64'h100C);
      check("wr_hi_w", 64'(w_log[0]), {28'd0, 4'hF, 32'h1111_2222});
    end

    // Empty strobe: no downstream traffic.
    clear_logs();
    write_txn("wr_empty", 64'h1008, 64'h1111_2222_3333_4444, 8'h00, 1, 0);
    check("wr_empty_nbeats", 64'(aw_log.size() + w_log.size()), 64'd0);

    // Read assembled from two beats with an error on the second.
    clear_logs();
    rd_data[0] = 32'hAAAA_AAAA; rd_resp[0] = 2'b00;
    rd_data[1] = 32'hBBBB_BBBB; rd_resp[1] = 2'b10;
    up_araddr = 64'h2004; up_arvalid = 1;
    wait_accept("rd", who);
    check("rd_grant", 64'(who), 64'(2'b01));
    @(negedge clk);
    up_arvalid = 0;
    wait_r("rd", 5, 64'hBBBB_BBBB_AAAA_AAAA, 2'b10);
    check("rd_nbeats", 64'(ar_log.size()), 64'd2);
    if (ar_log.size() == 2) begin
      check("rd_a0", ar_log[0], 64'h2000);
      check("rd_a1", ar_log[1], 64'h2004);
    end

    // Arbitration: first contest after reset goes to the write, the next to the read.
    apply_reset();
    clear_logs();
    rd_data[0] = 32'h0000_0001; rd_resp[0] = 2'b00;
    rd_data[1] = 32'h0000_0002; rd_resp[1] = 2'b01;
    start_write(64'h3000, 64'h5555_6666_7777_8888, 8'hFF);
    up_araddr = 64'h4000; up_arvalid = 1;
    wait_accept("arb1", who);
    check("arb1_grant", 64'(who), 64'(2'b10));
    @(negedge clk);
    up_awvalid = 0; up_wvalid = 0;
    wait_b("arb1", 5, 2'b00, 0);
    start_write(64'h3010, 64'h9999_AAAA_BBBB_CCCC, 8'hFF);
    wait_accept("arb2", who);
    check("arb2_grant", 64'(who), 64'(2'b01));
    @(negedge clk);
    up_arvalid = 0;
    wait_r("arb2", 5, 64'h0000_0002_0000_0001, 2'b01);
    wait_accept("arb3", who);
    check("arb3_grant", 64'(who), 64'(2'b10));
    @(negedge clk);
    up_awvalid = 0; up_wvalid = 0;
    wait_b("arb3", 5, 2'b00, 0);

    // Downstream AW backpressure plus upstream B backpressure.
    clear_logs();
    aw_stall = 3;
    write_txn("bp", 64'h5000, 64'h0123_4567_89AB_CDEF, 8'hFF, 8, 4);
    check("bp_awvalid_cycles", 64'(awv_cnt), 64'd5);
    check("bp_wvalid_cycles", 64'(wv_cnt), 64'd2);
    check("bp_bready_first", 64'(bready_cyc - t0), 64'd5);
    aw_stall = 0;

    // Reset while waiting for the downstream write response.
    clear_logs();
    start_write(64'h6000, 64'hFFFF_EEEE_DDDD_CCCC, 8'hFF);
    wait_accept("rstmid", who);
    @(negedge clk);
    up_awvalid = 0; up_wvalid = 0;
    for (int i = 0; i < 20 && !dn_bready; i++) @(negedge clk);
    check("rstmid_in_wrsp", 64'(dn_bready), 64'd1);
    rst_n = 0;
    @(negedge clk);
    check("rstmid_valids", 64'({up_awready, up_arready, up_bvalid, up_rvalid, dn_awvalid,
                                dn_wvalid, dn_bready, dn_arvalid, dn_rready}), 64'd0);
    @(negedge clk);
    rst_n = 1;
    clear_logs();
    write_txn("post_rst", 64'h7010, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 5, 0);
    check("post_rst_nbeats", 64'(aw_log.size()), 64'd2);
    if (aw_log.size() == 2 && w_log.size() == 2) begin
      check("post_rst_a0", aw_log[0], 64'h7010);
      check("post_rst_a1", aw_log[1], 64'h7014);
      check("post_rst_w1", 64'(w_log[1]), {28'd0, 4'hF, 32'hDEAD_BEEF});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axi_lite_width_downsizer.md
# axi_lite_width_downsizer

Parametrised AXI4-Lite width adapter: a wide upstream master port (core/chipset side, default 64-bit) is narrowed to a downstream slave port of SLV_DW bits (e.g. 32-bit UART), generalising the fixed per-peripheral AXI-Lite links in the chipset.
- Each upstream write is split into up to RATIO = MST_DW/SLV_DW sequential narrow writes; zero-strobe beats are optionally skipped.
- Each upstream read is assembled from RATIO narrow reads.
- Per-beat responses are merged into one upstream response.
- Reads and writes are arbitrated round-robin.
- One transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 64, address width, both ports.
- MST_DW, 64, upstream data width; power of 2, at least 2×SLV_DW.
- SLV_DW, 32, downstream data width; power of 2, at least 8.
- SKIP_EMPTY, 1, 1 = omit write beats whose strobe slice is all zero.

Ports (one clock; reset is synchronous and active-low):
- chipset_clk  in  1  clock; all logic on the rising edge.
- chipset_rst_n  in  1  synchronous active-low reset.
- up_awaddr/up_awvalid/up_awready  in/in/out  ADDR_W/1/1  upstream write address.
- up_wdata/up_wstrb/up_wvalid/up_wready  in/in/in/out  MST_DW/MST_DW/8/1/1  upstream write data.
- up_bresp/up_bvalid/up_bready  out/out/in  2/1/1  upstream write response.
- up_araddr/up_arvalid/up_arready  in/in/out  ADDR_W/1/1  upstream read address.
- up_rdata/up_rresp/up_rvalid/up_rready  out/out/out/in  MST_DW/2/1/1  upstream read data.
- dn_awaddr/dn_awvalid/dn_awready  out/out/in  ADDR_W/1/1  downstream write address.
- dn_wdata/dn_wstrb/dn_wvalid/dn_wready  out/out/out/in  SLV_DW/SLV_DW/8/1/1  downstream write data.
- dn_bresp/dn_bvalid/dn_bready  in/in/out  2/1/1  downstream write response.
- dn_araddr/dn_arvalid/dn_arready  out/out/in  ADDR_W/1/1  downstream read address.
- dn_rdata/dn_rresp/dn_rvalid/dn_rready  in/in/in/out  SLV_DW/2/1/1  downstream read data.

## Operation
- States:
  - IDLE
  - W_REQ: dn AW/W outstanding.
  - W_RSP: awaiting dn B.
  - W_DONE: up B valid.
  - R_REQ: dn AR outstanding.
  - R_RSP: awaiting dn R.
  - R_DONE: up R valid.
- Write pending in IDLE means up_awvalid && up_wvalid. AW and W are always accepted together: up_awready = up_wready = 1 for that single cycle.
- Read pending in IDLE means up_arvalid.
- Arbitration when both are pending: the kind not served last wins. The last-served flag resets to "read", so the first contest after reset goes to the write.
- Capture: address, data and strobe are registered.
  - Base = address with the low log2(MST_DW/8) bits cleared.
  - Beat k address = base + k·SLV_DW/8.
  - Beat k data/strobe = slice k of the captured data/strobe.
- Write beat order is ascending k.
  - SKIP_EMPTY=1: only beats with a nonzero strobe slice are issued.
  - If no beat qualifies: no downstream traffic; go directly to W_DONE with OKAY.
  - SKIP_EMPTY=0: all RATIO beats are issued.
- W_REQ:
  - dn_awvalid and dn_wvalid both assert; each deasserts independently on its own handshake.
  - When both have completed, go to W_RSP with dn_bready=1.
  - On the B handshake: next beat → W_REQ; last beat → W_DONE.
- Reads: RATIO beats in ascending order, R_REQ → R_RSP (dn_rready=1). Each dn_rdata goes into slice k of the assembly register.
- Response merge: up resp = numerically largest beat resp (OKAY < EXOKAY < SLVERR < DECERR). An error does not abort the remaining beats.
- W_DONE / R_DONE: hold valid and payload until up_bready / up_rready, then return to IDLE.
- Reset values:
  - All valid and ready outputs 0.
  - dn_bready, dn_rready 0.
  - All address/data/strobe/resp outputs 0.
  - State IDLE.
- Reset asserted mid-transaction: everything returns to reset values on the next edge. The in-flight transaction is dropped, with no downstream completion tracking.

## Timing
- Accept cycle T0 (upstream ready high). Downstream request valid from T1, registered.
- Ideal slave (ready constant 1, response in the cycle after the request handshake), RATIO=2:
  - Beat 0 request at T1, response at T2.
  - Beat 1 request at T3, response at T4.
  - up_bvalid / up_rvalid at T5.
  - General ideal-slave latency: 2·beats+1.
- All-empty write (SKIP_EMPTY=1): up_bvalid at T1.
- No combinational paths from any input to any output, except nothing (all outputs registered).
- Upstream ready is 0 in every state except IDLE. No new acceptance until the done-state handshake.

## Test plan
- Write addr 0x1008, data 0x1111_2222_3333_4444, strb 0xFF, ideal slave:
  - dn write 0x1008/0x33334444/0xF at T1.
  - dn write 0x100C/0x11112222/0xF at T3.
  - up_bvalid at T5, OKAY.
- Write strb 0xF0, SKIP_EMPTY=1: single dn write 0x100C/0x11112222; up_bvalid at T3. Strb 0x00: no dn traffic, up_bvalid at T1, bresp 0.
- Read 0x2004, slave returns beat 0 0xAAAAAAAA OKAY, beat 1 0xBBBBBBBB SLVERR:
  - dn_araddr 0x2000 then 0x2004.
  - up_rdata 0xBBBBBBBB_AAAAAAAA, rresp 2'b10.
- Write and read both pending in the same IDLE cycle after reset: write served first. Repeat the contest: read served first.
- Backpressure:
  - dn_awready low 3 cycles while dn_wready=1: dn_wvalid drops after 1 cycle, dn_awvalid held 4 cycles, dn_bready only after both.
  - up_bready low 4 cycles: up_bvalid/bresp stable, up_awready stays 0.
- Reset mid-transaction: chipset_rst_n low during W_RSP: next edge all valids 0, state IDLE, then a fresh write completes normally.
